// File: rtl/prog_loader_pkg.sv
// Shared constants, state encoding and image-size helpers for the program loader.
package prog_loader_pkg;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   typedef enum logic [2:0] {
      IDLE,
      RECV,
      CHECK,
      SHIFT,
      DONE
   } loader_state_t;

   function automatic int prog_bits(input int sc, input int iw);
      return sc * (2 ** iw) * $clog2(sc);
   endfunction

   function automatic int prog_bytes(input int sc, input int iw);
      return (prog_bits(sc, iw) + 7) / 8;
   endfunction

endpackage

// File: rtl/prog_loader_buffer.sv
// Program image store: byte-wide write port, single-bit read mux.
module prog_loader_buffer #(
   parameter int NBYTES = 48,
   parameter int AW     = 6,
   parameter int BW     = 9
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          wr_en_i,
   input  logic [AW-1:0] wr_addr_i,
   input  logic [7:0]    wr_data_i,
   input  logic [BW-1:0] rd_idx_i,
   output logic          rd_bit_o
);

   logic [7:0]    mem_q [NBYTES];
   logic [BW-4:0] rd_byte;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NBYTES; i++) begin
            mem_q[i] <= '0;
         end
      end else if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   assign rd_byte = rd_idx_i[BW-1:3];

   // Indices past the image (one-past-end lookahead) read as 0.
   always_comb begin
      rd_bit_o = 1'b0;
      if (int'(rd_byte) < NBYTES) begin
         rd_bit_o = mem_q[rd_byte][rd_idx_i[2:0]];
      end
   end

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream receiver that checksums a program image and shifts it out bit-serially.
module prog_loader #(
   parameter int STATE_COUNT    = 8,
   parameter int INPUT_WIDTH    = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] byte_data,
   input  logic       byte_valid,
   output logic       byte_ready,
   output logic       prog_enable,
   output logic       prog_data,
   output logic       busy,
   output logic       done,
   output logic       error
);

   import prog_loader_pkg::*;

   localparam int PB = prog_bits(STATE_COUNT, INPUT_WIDTH);
   localparam int NB = prog_bytes(STATE_COUNT, INPUT_WIDTH);
   localparam int CW = $clog2(NB + 1);
   localparam int BW = $clog2(PB + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   loader_state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [BW-1:0] bit_q, bit_d;
   logic [TW-1:0] idle_q, idle_d;
   logic [7:0]    sum_q, sum_d;
   logic          err_q, err_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          pen_q, pen_d;
   logic          pdat_q, pdat_d;
   logic          rdy_q, rdy_d;

   logic          xfer;
   logic          wr_en;
   logic [BW-1:0] rd_idx;
   logic          rd_bit;

   assign xfer = byte_valid && rdy_q;

   // Look one bit ahead so prog_data is registered alongside prog_enable.
   assign rd_idx = (state_q == SHIFT) ? bit_q + BW'(1) : '0;

   prog_loader_buffer #(
      .NBYTES (NB),
      .AW     (CW),
      .BW     (BW)
   ) u_buf (
      .clk_i     (clock),
      .rst_i     (reset),
      .wr_en_i   (wr_en),
      .wr_addr_i (cnt_q),
      .wr_data_i (byte_data),
      .rd_idx_i  (rd_idx),
      .rd_bit_o  (rd_bit)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      idle_d  = idle_q;
      sum_d   = sum_q;
      err_d   = err_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      pen_d   = 1'b0;
      pdat_d  = 1'b0;
      wr_en   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (xfer && byte_data == SYNC_BYTE) begin
               state_d = RECV;
               err_d   = 1'b0;
               busy_d  = 1'b1;
               cnt_d   = '0;
               sum_d   = '0;
               idle_d  = '0;
            end
         end
         RECV: begin
            if (xfer) begin
               idle_d = '0;
               sum_d  = sum_q + byte_data;
               if (cnt_q == CW'(NB)) begin
                  state_d = CHECK;
               end else begin
                  wr_en = 1'b1;
                  cnt_d = cnt_q + CW'(1);
               end
            end else if (idle_q == TW'(TIMEOUT_CYCLES - 1)) begin
               state_d = IDLE;
               err_d   = 1'b1;
               busy_d  = 1'b0;
            end else begin
               idle_d = idle_q + TW'(1);
            end
         end
         CHECK: begin
            if (sum_q == 8'h00) begin
               state_d = SHIFT;
               bit_d   = '0;
               pen_d   = 1'b1;
               pdat_d  = rd_bit;
            end else begin
               state_d = IDLE;
               err_d   = 1'b1;
               busy_d  = 1'b0;
            end
         end
         SHIFT: begin
            if (bit_q == BW'(PB - 1)) begin
               state_d = DONE;
               done_d  = 1'b1;
            end else begin
               bit_d  = bit_q + BW'(1);
               pen_d  = 1'b1;
               pdat_d = rd_bit;
            end
         end
         DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: state_d = IDLE;
      endcase
      rdy_d = (state_d == IDLE) || (state_d == RECV);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         idle_q  <= '0;
         sum_q   <= '0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pen_q   <= 1'b0;
         pdat_q  <= 1'b0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         idle_q  <= idle_d;
         sum_q   <= sum_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pen_q   <= pen_d;
         pdat_q  <= pdat_d;
         rdy_q   <= rdy_d;
      end
   end

   assign byte_ready  = rdy_q;
   assign prog_enable = pen_q;
   assign prog_data   = pdat_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign error       = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with a timeline-level reference model.
module tb_prog_loader;

   localparam int PB = 384;
   localparam int NB = 48;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] byte_data = 8'h00;
   logic       byte_valid = 1'b0;
   logic       byte_ready, prog_enable, prog_data, busy, done, error;

   prog_loader dut (
      .clock       (clock),
      .reset       (reset),
      .byte_data   (byte_data),
      .byte_valid  (byte_valid),
      .byte_ready  (byte_ready),
      .prog_enable (prog_enable),
      .prog_data   (prog_data),
      .busy        (busy),
      .done        (done),
      .error       (error)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: tracks frames and schedules output windows by edge number.
   int         e_no = 0;
   bit         started = 1'b0;
   bit         in_frame = 1'b0;
   int         nrx = 0;
   int         idle = 0;
   logic [7:0] pay [NB];
   logic [7:0] img [NB];
   int         shift_lo = -1;
   int         err_at = -1;
   int         busy_clr = -1;
   int         block_hi = -1;
   bit         exp_ready = 0, exp_busy = 0, exp_err = 0;
   bit         exp_en = 0, exp_data = 0, exp_done = 0;

   always @(posedge clock) begin : mdl
      int s;
      int k;
      e_no++;
      started = 1'b1;
      if (reset) begin
         in_frame = 0; nrx = 0; idle = 0;
         shift_lo = -1; err_at = -1; busy_clr = -1; block_hi = -1;
         exp_ready = 0; exp_busy = 0; exp_err = 0;
         exp_en = 0; exp_data = 0; exp_done = 0;
      end else begin
         if (byte_valid && exp_ready) begin
            if (!in_frame) begin
               if (byte_data == 8'hA5) begin
                  in_frame = 1; nrx = 0; idle = 0;
                  exp_err = 0; exp_busy = 1;
               end
            end else if (nrx < NB) begin
               pay[nrx] = byte_data;
               nrx++;
               idle = 0;
            end else begin
               s = int'(byte_data);
               for (int i = 0; i < NB; i++) s += int'(pay[i]);
               in_frame = 0;
               if (s % 256 == 0) begin
                  img = pay;
                  shift_lo = e_no + 1;
                  block_hi = e_no + PB + 1;
                  busy_clr = e_no + PB + 2;
               end else begin
                  block_hi = e_no;
                  err_at = e_no + 1;
               end
            end
         end else if (in_frame) begin
            idle++;
            if (idle == 1024) begin
               in_frame = 0; exp_err = 1; exp_busy = 0;
            end
         end
         if (e_no == err_at) begin
            exp_err = 1; exp_busy = 0;
         end
         if (e_no == busy_clr) exp_busy = 0;
         exp_en = shift_lo >= 0 && e_no >= shift_lo && e_no < shift_lo + PB;
         exp_data = 0;
         if (exp_en) begin
            k = e_no - shift_lo;
            exp_data = img[k / 8][k % 8];
         end
         exp_done = shift_lo >= 0 && e_no == shift_lo + PB;
         exp_ready = e_no > block_hi;
      end
   end

   int   en_cnt = 0;
   logic cap [512];

   always @(negedge clock) begin
      if (started) begin
         chk("ready", byte_ready, exp_ready);
         chk("prog_enable", prog_enable, exp_en);
         chk("prog_data", prog_data, exp_data);
         chk("busy", busy, exp_busy);
         chk("done", done, exp_done);
         chk("error", error, exp_err);
         if (prog_enable === 1'b1) begin
            if (en_cnt < 512) cap[en_cnt] = prog_data;
            en_cnt++;
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, output int n);
      logic r;
      n = 0;
      byte_data = b;
      byte_valid = 1'b1;
      do begin
         r = byte_ready;
         @(negedge clock);
         n++;
      end while (r !== 1'b1 && n < 2000);
      byte_valid = 1'b0;
      if (r !== 1'b1) begin
         total++;
         bad++;
         $display("FAIL accept: byte %h not taken after %0d cycles", b, n);
      end
   endtask

   task automatic send_body(input logic [7:0] ck);
      int n;
      for (int i = 0; i < NB; i++) send_byte(i[7:0], n);
      send_byte(ck, n);
   endtask

   task automatic send_frame(input logic [7:0] ck);
      int n;
      send_byte(8'hA5, n);
      send_body(ck);
   endtask

   task automatic expect_load(input string tag);
      int k;
      logic [23:0] lit;
      lit = 24'h020100;
      k = 0;
      while (done !== 1'b1 && k < 1000) begin
         @(negedge clock);
         k++;
      end
      chk({tag, "_done_lat"}, k, 385);
      chk({tag, "_en_cycles"}, en_cnt, PB);
      for (int i = 0; i < 24; i++) chk({tag, "_bit"}, cap[i], lit[i]);
      chk({tag, "_bit376"}, cap[376], 1'b1);
      chk({tag, "_bit383"}, cap[383], 1'b0);
      chk({tag, "_err"}, error, 1'b0);
      @(negedge clock);
      chk({tag, "_ready_after"}, byte_ready, 1'b1);
      chk({tag, "_busy_after"}, busy, 1'b0);
      chk({tag, "_done_pulse"}, done, 1'b0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      repeat (3) @(negedge clock);
      chk("rst_ready", byte_ready, 1'b0);
      chk("rst_en", prog_enable, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_err", error, 1'b0);
      reset = 1'b0;
      @(negedge clock);
      chk("post_rst_ready", byte_ready, 1'b1);

      en_cnt = 0;
      send_frame(8'h98);
      expect_load("t1");

      en_cnt = 0;
      send_frame(8'h99);
      chk("t2_check_ready", byte_ready, 1'b0);
      @(negedge clock);
      chk("t2_err", error, 1'b1);
      chk("t2_ready", byte_ready, 1'b1);
      chk("t2_busy", busy, 1'b0);
      repeat (400) @(negedge clock);
      chk("t2_no_enable", en_cnt, 0);

      send_byte(8'h00, n);
      chk("t3_busy0", busy, 1'b0);
      send_byte(8'hFF, n);
      chk("t3_busy1", busy, 1'b0);
      send_byte(8'h5A, n);
      chk("t3_busy2", busy, 1'b0);
      chk("t3_err_sticky", error, 1'b1);
      en_cnt = 0;
      send_frame(8'h98);
      expect_load("t3");

      send_byte(8'hA5, n);
      for (int i = 0; i < 10; i++) send_byte(i[7:0], n);
      repeat (1023) @(negedge clock);
      chk("t4_err_early", error, 1'b0);
      chk("t4_busy_early", busy, 1'b1);
      @(negedge clock);
      chk("t4_err", error, 1'b1);
      chk("t4_busy", busy, 1'b0);
      chk("t4_ready", byte_ready, 1'b1);
      en_cnt = 0;
      send_frame(8'h98);
      expect_load("t4");

      send_frame(8'h98);
      repeat (101) @(negedge clock);
      chk("t5_mid_en", prog_enable, 1'b1);
      reset = 1'b1;
      @(negedge clock);
      chk("t5_en", prog_enable, 1'b0);
      chk("t5_busy", busy, 1'b0);
      chk("t5_ready", byte_ready, 1'b0);
      chk("t5_data", prog_data, 1'b0);
      reset = 1'b0;
      @(negedge clock);
      chk("t5_ready_back", byte_ready, 1'b1);

      en_cnt = 0;
      send_frame(8'h98);
      send_byte(8'hA5, n);
      chk("t6_wait", n, 387);
      chk("t6_f1_en", en_cnt, PB);
      en_cnt = 0;
      send_body(8'h98);
      expect_load("t6");

      repeat (5) @(negedge clock);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
